// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment digit path: active-low segment
// glyphs (a..g on bits 0..6), blank/off codes and the digit-index type.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;
    localparam logic [3:0] ANODE_D0  = 4'b1110;

    typedef logic [1:0] digit_idx_t;

    // Active-low glyphs for hex digits 0..F (bit 6 = g ... bit 0 = a).
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble -> active-low cathode decoder using the package glyphs.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_GLYPH[nibble_i];

endmodule

// File: rtl/seven_seg_digit_driver.sv
// Four-digit seven-segment driver behind the anode scanner. Re-times the
// scanner's anode word and drives matching cathodes from a double-buffered
// 16-bit value that only changes at a frame boundary (digit 0 activating).
// Optional leading-zero blanking: define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_digit_driver
    import seven_seg_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  anode_in,
    input  logic [15:0] value,
    input  logic        load,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        pending
);

    logic [15:0] shadow_q, shadow_d;
    logic [15:0] active_q, active_d;
    logic        pending_q, pending_d;
    logic [3:0]  anode_q, anode_d;
    logic [6:0]  cathode_q, cathode_d;

    logic        word_valid;
    digit_idx_t  digit_idx;
    logic        frame_start;
    logic        transfer;
    logic [3:0]  nibble;
    logic [6:0]  glyph;
    logic        lz_blank;

    // Classify the anode word: exactly one low bit selects a digit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        word_valid = 1'b1;
        digit_idx  = 2'd0;
        case (anode_in)
            4'b1110: digit_idx = 2'd0;
            4'b1101: digit_idx = 2'd1;
            4'b1011: digit_idx = 2'd2;
            4'b0111: digit_idx = 2'd3;
            default: word_valid = 1'b0;
        endcase
    end

    assign frame_start = word_valid && (anode_in == ANODE_D0) && (anode_q != ANODE_D0);
    assign transfer    = frame_start && pending_q;

    // Double buffer: load fills the shadow, a frame start moves it to active.
    // A coincident load leaves pending set since the new shadow is unseen.
    always_comb begin
        active_d  = transfer ? shadow_q : active_q;
        shadow_d  = load ? value : shadow_q;
        pending_d = pending_q;
        if (transfer) pending_d = 1'b0;
        if (load)     pending_d = 1'b1;
    end

    // Pick the nibble of the transfer-updated value for the selected digit.
    always_comb begin
        nibble = active_d[3:0];
        case (digit_idx)
            2'd0: nibble = active_d[3:0];
            2'd1: nibble = active_d[7:4];
            2'd2: nibble = active_d[11:8];
            2'd3: nibble = active_d[15:12];
            default: nibble = active_d[3:0];
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // Blank a digit above 0 when it and every higher digit are zero.
    always_comb begin
        lz_blank = 1'b0;
        case (digit_idx)
            2'd1: lz_blank = (active_d[15:4]  == 12'h000);
            2'd2: lz_blank = (active_d[15:8]  == 8'h00);
            2'd3: lz_blank = (active_d[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Output next-state: invalid words blank the display entirely.
    always_comb begin
        anode_d   = word_valid ? anode_in : ANODE_OFF;
        cathode_d = (word_valid && !lz_blank) ? glyph : SEG_BLANK;
    end

    // State registers; reset blanks the display and clears both buffers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the value buffers are reset too so the first frame after
            // release deterministically shows 0000.
            shadow_q  <= 16'h0000;
            active_q  <= 16'h0000;
            pending_q <= 1'b0;
            anode_q   <= ANODE_OFF;
            cathode_q <= SEG_BLANK;
        end else begin
            // NOTE: non-blocking so all registers update from pre-edge values.
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Self-checking bench for seven_seg_digit_driver: a transaction-level model
// pushes expected outputs per driven cycle; they are popped and compared
// one clock later. Directed literal checks cover the notable scenarios.
module tb_seven_seg_digit_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  anode_in = 4'hF;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        pending;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] cathode;
        logic       pending;
    } exp_t;

    exp_t sb_q[$];

    // Model state
    logic [15:0] m_shadow, m_active;
    logic        m_pending;
    logic [3:0]  m_anode;

    seven_seg_digit_driver dut (
        .clock    (clock),
        .reset    (reset),
        .anode_in (anode_in),
        .value    (value),
        .load     (load),
        .anode    (anode),
        .cathode  (cathode),
        .pending  (pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic model_reset();
        m_shadow  = 16'h0000;
        m_active  = 16'h0000;
        m_pending = 1'b0;
        m_anode   = 4'hF;
    endtask

    // Drive one cycle, predict the registered result, then compare it.
    task automatic step(input logic [3:0] a, input logic ld, input logic [15:0] v);
        exp_t e;
        exp_t got;
        int   zeros;
        int   idx;
        logic fs;
        logic blank;
        @(negedge clock);
        anode_in = a;
        load     = ld;
        value    = v;
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; idx = i; end
        fs = (zeros == 1) && (a == 4'b1110) && (m_anode != 4'b1110);
        if (fs && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (ld) begin
            m_shadow  = v;
            m_pending = 1'b1;
        end
        blank = 1'b0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
        if (idx > 0) begin
            blank = 1'b1;
            for (int j = idx; j < 4; j++) if (m_active[j*4 +: 4] != 4'h0) blank = 1'b0;
        end
`endif
        e.anode   = (zeros == 1) ? a : 4'hF;
        e.cathode = (zeros == 1 && !blank) ? ref_glyph(m_active[idx*4 +: 4]) : 7'h7F;
        e.pending = m_pending;
        m_anode   = e.anode;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        load = 1'b0;
        got = sb_q.pop_front();
        check("anode", {28'd0, anode}, {28'd0, got.anode});
        check("cathode", {25'd0, cathode}, {25'd0, got.cathode});
        check("pending", {31'd0, pending}, {31'd0, got.pending});
    endtask

    task automatic run_frame();
        step(4'b1110, 1'b0, 16'h0);
        step(4'b1101, 1'b0, 16'h0);
        step(4'b1011, 1'b0, 16'h0);
        step(4'b0111, 1'b0, 16'h0);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_anode", {28'd0, anode}, 32'hF);
        check("rst_cathode", {25'd0, cathode}, 32'h7F);
        check("rst_pending", {31'd0, pending}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Post-reset frame shows 0 on every digit.
        run_frame();
        check("zero_d3", {25'd0, cathode}, 32'h40);

        // Mid-frame load at digit 2; visible from next frame.
        step(4'b1110, 1'b0, 16'h0);
        step(4'b1101, 1'b0, 16'h0);
        step(4'b1011, 1'b1, 16'hA18F);
        check("load_pend", {31'd0, pending}, 32'h1);
        check("load_old", {25'd0, cathode}, 32'h40);
        step(4'b0111, 1'b0, 16'h0);
        step(4'b1110, 1'b0, 16'h0);
        check("a18f_d0", {25'd0, cathode}, {25'd0, 7'b0001110});
        check("a18f_pend", {31'd0, pending}, 32'h0);
        step(4'b1101, 1'b0, 16'h0);
        check("a18f_d1", {25'd0, cathode}, {25'd0, 7'b0000000});
        step(4'b1011, 1'b0, 16'h0);
        check("a18f_d2", {25'd0, cathode}, {25'd0, 7'b1111001});
        step(4'b0111, 1'b0, 16'h0);
        check("a18f_d3", {25'd0, cathode}, {25'd0, 7'b0001000});

        // Load coincident with transfer: 5678 now, 1234 next frame.
        step(4'b1101, 1'b1, 16'h5678);
        step(4'b1011, 1'b0, 16'h0);
        step(4'b0111, 1'b0, 16'h0);
        step(4'b1110, 1'b1, 16'h1234);
        check("coin_d0", {25'd0, cathode}, {25'd0, 7'b0000000});
        check("coin_pend", {31'd0, pending}, 32'h1);
        step(4'b1101, 1'b0, 16'h0);
        step(4'b1011, 1'b0, 16'h0);
        step(4'b0111, 1'b0, 16'h0);
        check("coin_d3", {25'd0, cathode}, {25'd0, 7'b0010010});
        step(4'b1110, 1'b0, 16'h0);
        check("next_d0", {25'd0, cathode}, {25'd0, 7'b0011001});
        check("next_pend", {31'd0, pending}, 32'h0);
        step(4'b1101, 1'b0, 16'h0);

        // Invalid words blank; a following 1110 still transfers.
        step(4'b1011, 1'b1, 16'h9C3D);
        step(4'b1100, 1'b0, 16'h0);
        check("inv_anode", {28'd0, anode}, 32'hF);
        check("inv_cathode", {25'd0, cathode}, 32'h7F);
        step(4'b1111, 1'b0, 16'h0);
        step(4'b1110, 1'b0, 16'h0);
        check("inv_xfer_d0", {25'd0, cathode}, {25'd0, 7'b0100001});
        check("inv_xfer_pend", {31'd0, pending}, 32'h0);

        // Async reset mid-frame with a pending load.
        step(4'b1101, 1'b1, 16'h4321);
        #2;
        reset = 1'b1;
        #1;
        check("arst_anode", {28'd0, anode}, 32'hF);
        check("arst_cathode", {25'd0, cathode}, 32'h7F);
        check("arst_pending", {31'd0, pending}, 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        run_frame();
        check("arst_zero", {25'd0, cathode}, 32'h40);

`ifdef SEVEN_SEG_LZ_BLANK_EN
        step(4'b1110, 1'b1, 16'h0040);
        step(4'b1101, 1'b0, 16'h0);
        step(4'b1011, 1'b0, 16'h0);
        step(4'b0111, 1'b0, 16'h0);
        check("lz_d3", {25'd0, cathode}, 32'h7F);
        step(4'b1110, 1'b0, 16'h0);
        check("lz_d0", {25'd0, cathode}, 32'h40);
        step(4'b1101, 1'b0, 16'h0);
        check("lz_d1", {25'd0, cathode}, {25'd0, 7'b0011001});
        step(4'b1011, 1'b1, 16'h0000);
        check("lz_d2", {25'd0, cathode}, 32'h7F);
        step(4'b0111, 1'b0, 16'h0);
        run_frame();
        check("lz0_d3", {25'd0, cathode}, 32'h7F);
`endif

        // Random mix of valid/invalid words and loads.
        for (int n = 0; n < 60; n++) begin
            logic [3:0] a;
            case ($urandom_range(0, 5))
                0: a = 4'b1110;
                1: a = 4'b1101;
                2: a = 4'b1011;
                3: a = 4'b0111;
                4: a = 4'($urandom_range(0, 15));
                default: a = 4'b1110;
            endcase
            step(a, ($urandom_range(0, 3) == 0), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_digit_driver.md
# seven_seg_digit_driver

Downstream companion of the seven-segment anode scanner. Takes the scanner's active-low one-hot anode word plus a 16-bit hex value from the datapath, then drives re-timed anodes and matching active-low cathodes for the four-digit display. A double buffer applies new values only at a frame boundary (digit 0 becoming active), so a displayed number never tears mid-scan.

## Interface
Parameters: none.

Ports:
- clock  in  1  system clock; the scanner's div_clock is derived from it
- reset  in  1  asynchronous, active-high; one clock (`clock`), reset is asynchronous and active-high
- anode_in  in  4  scanner anode word, active-low, bit 0 = R … bit 3 = L
- value  in  16  hex value to display; nibble k shows on digit k (nibble 0 = R)
- load  in  1  single-cycle strobe; captures `value` into the shadow register
- anode  out  4  re-timed anode drive, active-low
- cathode  out  7  segments a..g on bits 0..6, active-low
- pending  out  1  high while the shadow holds a value not yet shown

## Operation
- Registers: `shadow[15:0]`, `active[15:0]`, `pending`, `anode_q[3:0]`, `cathode_q[6:0]`. `anode`/`cathode` are driven directly from `anode_q`/`cathode_q`.
- Load: on `load`, `shadow <= value` and `pending <= 1`.
- Frame start: `frame_start = (anode_in == 4'b1110) && (anode_q != 4'b1110)`.
- Transfer: on frame_start with `pending` = 1, `active <= shadow` and `pending <= 0`.
- Load coincident with transfer:
  - The transfer uses the pre-load shadow.
  - The shadow takes the new value.
  - `pending` ends the cycle at 1.
- Digit select, each cycle:
  - Valid word (exactly one zero bit in `anode_in`): select the nibble of `active_next` for that digit, where `active_next` is the transfer-updated value, so digit 0 shows new data on the first frame. Then `cathode_q <= hex_decode(nibble)` and `anode_q <= anode_in`.
  - Invalid word (0 or ≥2 zero bits): `anode_q <= 4'hF`, `cathode_q <= 7'h7F` (blank). An invalid word never counts as a frame start. A later 1110 after an invalid word does count, because `anode_q` = F.
- Decode, active-low:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011
  - C→1000110, d→0100001, E→0000110, F→0001110
- No arithmetic; nibble indexing only.

## Timing
- Reset values: `anode` = 4'hF, `cathode` = 7'h7F, `pending` = 0, `shadow` = 0, `active` = 0.
- Reset is asynchronous, so outputs blank immediately, including mid-frame or with a pending load. The first valid anode word after release shows 0 on all digits.
- Latency is 1 clock from `anode_in` to `anode`/`cathode`; the two outputs always change on the same edge, so there is no ghosting.
- Load to visible:
  - Best case 1 clock: `load` in the cycle before `anode_in` becomes 1110.
  - Worst case is one full scan frame.
- Repeated loads before a frame start: the last one wins; `pending` stays 1.
- If the scanner is stalled, for example held in reset, no transfer occurs and `pending` stays 1 indefinitely.

## Configuration
- `SEVEN_SEG_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digits 3..1 whose nibble is 0 output 7'h7F when all higher digits are also 0.
  - Digit 0 is never blanked.
  - `anode` is unaffected.
- Not defined: every digit always shows its hex glyph.

## Structure
- Shared package `seven_seg_pkg` holds:
  - the 16-entry segment glyph constants
  - `SEG_BLANK` = 7'h7F
  - `ANODE_OFF` = 4'hF
  - `ANODE_D0` = 4'b1110
  - a digit-index typedef (2 bits)
- One sub-module, `hex_to_seg`: purely combinational nibble→cathode decoder built from the package constants.
- All other logic lives in this block. Flops use asynchronous reset.

## Test plan
- Reset, then `anode_in` cycles 1110→1101→1011→0111: `cathode` = 1000000 on every digit, `anode` lags `anode_in` by 1 clock, `pending` = 0.
- `load` with `value` = 16'hA18F mid-frame at digit 2: `pending` = 1; the remaining digits keep showing 0. From the next 1110 onward, digits 0..3 show F (0001110), 8 (0000000), 1 (1111001), A (0001000), and `pending` = 0.
- `load` 16'h1234 in the same cycle `anode_in` goes to 1110 while shadow = 16'h5678 with `pending` = 1: this frame shows 5678, the next frame shows 1234, and `pending` is 1 in between.
- `anode_in` = 1100, then 1111: `anode` = 4'hF and `cathode` = 7'h7F one clock later. A subsequent 1110 triggers the transfer of a pending value.
- Reset asserted mid-frame with `pending` = 1: `anode` = F and `cathode` = 7F immediately. After release the display shows 0000.
- With `SEVEN_SEG_LZ_BLANK_EN`, `value` = 16'h0040: digits 3 and 2 blank, digit 1 shows 4, digit 0 shows 0. `value` = 16'h0000: only digit 0 shows 0.
